// File: rtl/vram_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_scan_arbiter
// Brief    : Shares one single-port synchronous video RAM between VGA
//            scan-out (owns the RAM during active display) and two writer
//            clients (round-robin with burst limit during blanking).
//            Optional blocked-request statistics: define VRAM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vram_scan_arbiter #(
  parameter int FB_W      = 160,
  parameter int FB_H      = 120,
  parameter int SHIFT     = 2,
  parameter int AW        = 15,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic          clk25M,
  input  logic          rst,
  input  logic          blank_n,
  input  logic [12:0]   X,
  input  logic [12:0]   Y,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic [15:0]   stall_cnt
);

  localparam int FB_SIZE = FB_W * FB_H;
  localparam int BW      = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    S_SCAN  = 2'd0,
    S_IDLE  = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_rr;
  logic [BW-1:0] r_burst;
  logic          r_ack0;
  logic          r_ack1;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic          r_blank_d1;
  logic          r_blank_d2;
  logic [DW-1:0] r_pix_data;
  logic          r_pix_valid;

  logic [AW-1:0] w_scan_row;
  logic [AW-1:0] w_scan_col;
  logic [AW-1:0] w_scan_addr;
  logic          w_granting;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_gnt_vld;
  logic          w_gnt_sel;
  logic          w_rr_nxt;
  logic [BW-1:0] w_burst_inc;
  logic [BW-1:0] w_burst_nxt;
  logic [AW-1:0] w_gnt_addr;
  logic [DW-1:0] w_gnt_wdata;
  logic          w_in_range;

  // Screen pixel to framebuffer word, wrapping in AW-bit arithmetic
  assign w_scan_row  = AW'(Y >> SHIFT);
  assign w_scan_col  = AW'(X >> SHIFT);
  assign w_scan_addr = w_scan_row * AW'(FB_W) + w_scan_col;

  // A client whose ack is on the wire this cycle sits out one decision,
  // otherwise its still-high req would be written a second time
  assign w_granting = (r_state == S_GRANT);
  assign w_elig0    = req0 & ~(w_granting & r_ack0);
  assign w_elig1    = req1 & ~(w_granting & r_ack1);

  assign w_burst_inc = r_burst + BW'(1);
  assign w_gnt_addr  = w_gnt_sel ? addr1  : addr0;
  assign w_gnt_wdata = w_gnt_sel ? wdata1 : wdata0;
  assign w_in_range  = (32'(w_gnt_addr) < 32'(FB_SIZE));

  // Round-robin selection and burst bookkeeping for the candidate grant
  always_comb begin
    w_gnt_vld   = w_elig0 | w_elig1;
    w_gnt_sel   = w_elig1 & (~w_elig0 | r_rr);
    w_rr_nxt    = r_rr;
    w_burst_nxt = r_burst;
    if (w_gnt_sel == r_rr) begin
      if (w_burst_inc == BW'(BURST_MAX)) begin
        w_rr_nxt    = ~r_rr;
        w_burst_nxt = '0;
      end else begin
        w_burst_nxt = w_burst_inc;
      end
    end else begin
      w_rr_nxt    = w_gnt_sel;
      w_burst_nxt = '0;
    end
  end

  // Arbiter FSM: owns the RAM port, acks and the round-robin state
  always_ff @(posedge clk25M or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr        <= 1'b0;
      r_burst     <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_mem_we <= 1'b0;
      if (blank_n) begin
        r_state    <= S_SCAN;
        r_mem_addr <= w_scan_addr;
      end else if (w_gnt_vld) begin
        r_state <= S_GRANT;
        r_rr    <= w_rr_nxt;
        r_burst <= w_burst_nxt;
        r_ack0  <= ~w_gnt_sel;
        r_ack1  <= w_gnt_sel;
        // Out-of-range writes are acked but dropped; the RAM port keeps its last address
        if (w_in_range) begin
          r_mem_addr  <= w_gnt_addr;
          r_mem_wdata <= w_gnt_wdata;
          r_mem_we    <= 1'b1;
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  // Scan-out return path: blank_n delayed to line up with RAM read data
  always_ff @(posedge clk25M or posedge rst) begin
    if (rst) begin
      r_blank_d1  <= 1'b0;
      r_blank_d2  <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
    end else begin
      r_blank_d1  <= blank_n;
      r_blank_d2  <= r_blank_d1;
      r_pix_valid <= r_blank_d2;
      r_pix_data  <= r_blank_d2 ? mem_rdata : '0;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  // Count cycles where a writer is blocked by scan-out, saturating
  always_ff @(posedge clk25M or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (blank_n && (req0 || req1) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'd0;
`endif

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign pix_data  = r_pix_data;
  assign pix_valid = r_pix_valid;

endmodule
`default_nettype wire

// File: doc/vram_scan_arbiter.md
# vram_scan_arbiter

Shares one single-port synchronous video RAM between the VGA scan-out path and two writer clients (game logic, text overlay). It sits between the 640x480 VGA timing generator and the framebuffer RAM. During the active display area, scan-out owns the RAM every cycle and the block returns pixel data. During blanking, writer requests are granted round-robin with a burst limit, using a req/ack handshake.

## Interface
- FB_W, 160: framebuffer width in words.
- FB_H, 120: framebuffer height in words.
- SHIFT, 2: screen-to-framebuffer downscale, as a power of 2.
- AW, 15: RAM address width. FB_W*FB_H must be ≤ 2^AW.
- DW, 8: pixel/RAM data width.
- BURST_MAX, 4: maximum consecutive grants to one client while the other client is requesting.

Ports:
- clk25M  in  1  pixel clock. The only clock.
- rst  in  1  reset. Asynchronous, active-high.
- blank_n  in  1  1 = active display area. Comes from the timing generator.
- X, Y  in  13 each  current active pixel coordinates.
- req0, req1  in  1 each  write request per client. Held until that client's ack.
- addr0, addr1  in  AW each  write address. Held stable while req is high.
- wdata0, wdata1  in  DW each  write data. Held stable while req is high.
- ack0, ack1  out  1 each  one-cycle pulse: write issued, or dropped if out of range.
- mem_addr  out  AW  RAM address. Registered.
- mem_wdata  out  DW  RAM write data. Registered.
- mem_we  out  1  RAM write enable. Registered.
- mem_rdata  in  DW  RAM read data. Valid one cycle after mem_addr.
- pix_data  out  DW  scan-out pixel. Registered.
- pix_valid  out  1  pix_data corresponds to an active pixel.
- stall_cnt  out  16  blocked-request statistic (see Configuration).

## Operation
- State machine: SCAN, IDLE, GRANT. The state is evaluated each cycle from the inputs sampled at that cycle.
  - blank_n=1 → SCAN, unconditionally. This covers a request arriving mid-active area and blank_n rising while in GRANT. No write is issued in SCAN.
  - blank_n=0 and no eligible request → IDLE.
  - blank_n=0 and an eligible request → GRANT for one cycle. Exactly one write is issued per GRANT cycle.
- Scan-out address: mem_addr = (Y>>SHIFT)*FB_W + (X>>SHIFT), computed in AW-bit unsigned arithmetic. In SCAN, mem_we=0.
- Eligibility: a client is eligible when its req=1 and its ack is not asserted in the current cycle. This one-cycle mask prevents a double write on a held req.
- Arbitration:
  - Round-robin pointer rr; reset value 0.
  - If only one client is eligible, that client is granted.
  - If both are eligible, client rr is granted. burst_cnt counts consecutive grants to the same client. When burst_cnt reaches BURST_MAX, rr flips and burst_cnt clears.
  - A grant to the non-rr client also sets rr to that client and clears burst_cnt.
- Write path: mem_addr←addrN, mem_wdata←wdataN, mem_we←1, ackN←1, all on the same registered edge.
- Out-of-range write (addrN ≥ FB_W*FB_H): ackN still pulses, mem_we stays 0, and mem_addr holds its previous value.
- Reset values:
  - All outputs 0: mem_addr, mem_wdata, mem_we, ack0, ack1, pix_data, pix_valid, stall_cnt.
  - State=IDLE, rr=0, burst_cnt=0.
- Reset asserted mid-grant: the pending ack and write are discarded. The client keeps req high and is re-served after reset.

## Timing
- Arbitration to RAM: a decision made in cycle t drives mem_addr/mem_we/ack in cycle t+1.
- Scan-out latency:
  - X/Y and blank_n are sampled in cycle t.
  - mem_addr is presented in t+1 and mem_rdata returns in t+2.
  - pix_data and pix_valid are registered in t+3. pix_valid is blank_n delayed by 3 cycles.
- When pix_valid=0, pix_data=0.
- Write throughput:
  - One client holding req continuously: one write every 2 cycles, because of the ack mask.
  - Both clients requesting: one write every cycle, alternating between clients.
- blank_n rising in cycle t: at most the write decided in t-1 completes in t. From t+1 onward, mem_addr carries scan addresses.

## Configuration
- VRAM_ARB_STATS_EN defined:
  - stall_cnt increments by 1 per cycle in which blank_n=1 and (req0|req1)=1.
  - It saturates at 0xFFFF and clears only on rst.
- VRAM_ARB_STATS_EN undefined: stall_cnt is tied to 0 and the counter logic is absent. All other behaviour is identical.

## Test plan
- Reset: assert rst asynchronously mid-frame → all outputs 0 immediately. After release, the first blanking grant goes to client 0 when both clients request.
- Scan: blank_n=1, X=5, Y=9 → mem_addr=2*160+1=321 in the next cycle. A RAM model returning 0xA5 → pix_data=0xA5 with pix_valid=1 three cycles after the X/Y input.
- Single client: blank_n=0, req0 held high with addr0=100, wdata0=0x3C → mem_we pulses with addr 100 and ack0 pulses every other cycle. No write occurs in the ack cycles.
- Burst and fairness: blank_n=0, req0 and req1 held high continuously → grants alternate client 0, client 1, client 0, client 1; neither client waits more than 1 cycle.
- Blanking boundary and range: a request pending when blank_n rises → no ack until blank_n falls. addr1=19200 → ack1 pulses and mem_we stays 0.
- Stats, with VRAM_ARB_STATS_EN defined: req0 held high for 10 active cycles → stall_cnt=10. Without the macro → stall_cnt remains 0.
